// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: 64-bit word -> LSB-first serial UI with gated forwarded clock,
// followed by an idle gap; one-entry pending buffer. Optional word counter via SB_SER_PKT_CNT_EN.
module sb_tx_serializer #(
  parameter int DATA_W = 64,
  parameter int GAP_UI = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sb_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_txdatasb,
  output logic              o_txcksb_en,
  output logic              o_ser_done,
  output logic              o_busy,
`ifdef SB_SER_PKT_CNT_EN
  output logic [15:0]       o_pkt_cnt,
`endif
  output logic              o_overflow
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW = (GAP_UI > 1) ? $clog2(GAP_UI) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              txd_q, txd_d;
  logic              cken_q, cken_d;
  logic              ovf_q, ovf_d;
  logic              last_gap;
  logic              load_en;
  logic [DATA_W-1:0] load_word;

  assign last_gap = (state_q == S_GAP) && (gap_cnt_q == GW'(GAP_UI - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      txd_q      <= 1'b0;
      cken_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      txd_q      <= txd_d;
      cken_q     <= cken_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    txd_d      = txd_q;
    cken_d     = cken_q;
    ovf_d      = 1'b0;
    load_en    = 1'b0;
    load_word  = i_data;

    if (!i_sb_en) begin
      state_d    = S_IDLE;
      shift_d    = '0;
      pend_vld_d = 1'b0;
      bit_cnt_d  = '0;
      gap_cnt_d  = '0;
      txd_d      = 1'b0;
      cken_d     = 1'b0;
    end else begin
      ovf_d = i_data_valid & pend_vld_q;
      // On the last gap UI an empty buffer lets the new word go straight to the shifter
      if (i_data_valid && !pend_vld_q && state_q != S_IDLE && !last_gap) begin
        pend_d     = i_data;
        pend_vld_d = 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (i_data_valid) load_en = 1'b1;
        end
        S_SHIFT: begin
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
            txd_d     = 1'b0;
            cken_d    = 1'b0;
          end else begin
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (last_gap) begin
            if (pend_vld_q) begin
              load_en    = 1'b1;
              load_word  = pend_q;
              pend_vld_d = 1'b0;
            end else if (i_data_valid) begin
              load_en = 1'b1;
            end else begin
              state_d   = S_IDLE;
              gap_cnt_d = '0;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Bit 0 goes straight to the output register so the first UI appears next cycle
      if (load_en) begin
        state_d   = S_SHIFT;
        txd_d     = load_word[0];
        cken_d    = 1'b1;
        shift_d   = load_word >> 1;
        bit_cnt_d = '0;
        gap_cnt_d = '0;
      end
    end
  end

`ifdef SB_SER_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      pkt_cnt_q <= '0;
    else if (!i_sb_en)
      pkt_cnt_q <= '0;
    else if (last_gap && pkt_cnt_q != 16'hFFFF)
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end
  assign o_pkt_cnt = pkt_cnt_q;
`endif

  assign o_txdatasb  = txd_q;
  assign o_txcksb_en = cken_q;
  assign o_ser_done  = last_gap;
  assign o_busy      = (state_q != S_IDLE) | pend_vld_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Directed bench for sb_tx_serializer: word timing, back-to-back, overflow, enable abort, async reset.
module tb_sb_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sb_en;
  logic [63:0] data;
  logic        valid;
  logic        txd, cken, done, busy, ovf;
`ifdef SB_SER_PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sb_tx_serializer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sb_en      (sb_en),
    .i_data       (data),
    .i_data_valid (valid),
    .o_txdatasb   (txd),
    .o_txcksb_en  (cken),
    .o_ser_done   (done),
    .o_busy       (busy),
`ifdef SB_SER_PKT_CNT_EN
    .o_pkt_cnt    (pkt_cnt),
`endif
    .o_overflow   (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue a single-cycle valid during the current cycle T; returns mid cycle T+1
  task automatic pulse(input logic [63:0] w);
    data  = w;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Check cycles T+1..T+96 of word w (called mid cycle T+1), optionally injecting
  // up to two extra valids at given cycle offsets; ovf_c is the expected overflow cycle.
  task automatic check_word(input string name, input logic [63:0] w,
                            input int inj1, input logic [63:0] d1,
                            input int inj2, input logic [63:0] d2, input int ovf_c);
    for (int c = 1; c <= 96; c++) begin
      chk($sformatf("%s_c%0d_txd", name, c), {63'd0, txd}, (c <= 64) ? {63'd0, w[c-1]} : 64'd0);
      chk($sformatf("%s_c%0d_cken", name, c), {63'd0, cken}, (c <= 64) ? 64'd1 : 64'd0);
      chk($sformatf("%s_c%0d_done", name, c), {63'd0, done}, (c == 96) ? 64'd1 : 64'd0);
      chk($sformatf("%s_c%0d_ovf", name, c), {63'd0, ovf}, (c == ovf_c) ? 64'd1 : 64'd0);
      chk($sformatf("%s_c%0d_busy", name, c), {63'd0, busy}, 64'd1);
      if (c == inj1) begin
        data = d1; valid = 1'b1;
      end else if (c == inj2) begin
        data = d2; valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic check_idle(input string name);
    chk({name, "_txd"},  {63'd0, txd},  64'd0);
    chk({name, "_cken"}, {63'd0, cken}, 64'd0);
    chk({name, "_done"}, {63'd0, done}, 64'd0);
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; sb_en = 1'b1; valid = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: alternating pattern
    pulse(64'hAAAA_AAAA_AAAA_AAAA);
    check_word("t1", 64'hAAAA_AAAA_AAAA_AAAA, -1, '0, -1, '0, -1);
    check_idle("t1_after");

    // 2: single high UI
    pulse(64'h1);
    check_word("t2", 64'h1, -1, '0, -1, '0, -1);
    check_idle("t2_after");

    // 3: second word issued at T+10 goes out back-to-back at T+97
    pulse(64'h0);
    check_word("t3w0", 64'h0, 10, 64'hFFFF_FFFF_FFFF_FFFF, -1, '0, -1);
    check_word("t3w1", 64'hFFFF_FFFF_FFFF_FFFF, -1, '0, -1, '0, -1);
    check_idle("t3_after");

    // 4: third valid within one word is dropped
    pulse(64'h0123_4567_89AB_CDEF);
    check_word("t4w0", 64'h0123_4567_89AB_CDEF, 5, 64'hDEAD_BEEF_0000_FFFF,
               10, 64'h5555_5555_5555_5555, 11);
    check_word("t4w1", 64'hDEAD_BEEF_0000_FFFF, -1, '0, -1, '0, -1);
    check_idle("t4_after");

    // 5: enable drop at T+40 aborts word and pending; valid while disabled ignored
    pulse(64'hFFFF_0000_FFFF_0000);
    for (int c = 1; c < 40; c++) begin
      valid = (c == 5);
      data  = 64'h1111_2222_3333_4444;
      @(negedge clk);
    end
    valid = 1'b0;
    chk("t5_busy_before", {63'd0, busy}, 64'd1);
    sb_en = 1'b0;
    @(negedge clk);
    check_idle("t5_abort");
    pulse(64'h7);
    check_idle("t5_dis_valid");
    repeat (2) @(negedge clk);
    check_idle("t5_dis_later");
    sb_en = 1'b1;
    @(negedge clk);
    pulse(64'h8000_0000_0000_0003);
    check_word("t5w", 64'h8000_0000_0000_0003, -1, '0, -1, '0, -1);
    check_idle("t5_after");

    // 6: async reset mid-word
    pulse(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (19) @(negedge clk);
    chk("t6_cken_before", {63'd0, cken}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle("t6_async");
`ifdef SB_SER_PKT_CNT_EN
    chk("t6_pkt_cnt_rst", {48'd0, pkt_cnt}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("t6_after_rst");
`ifdef SB_SER_PKT_CNT_EN
    pulse(64'h1);
    check_word("t6w0", 64'h1, 1, 64'h2, -1, '0, -1);
    check_word("t6w1", 64'h2, -1, '0, -1, '0, -1);
    pulse(64'h3);
    check_word("t6w2", 64'h3, -1, '0, -1, '0, -1);
    chk("t6_pkt_cnt3", {48'd0, pkt_cnt}, 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
